// File: rtl/mac_pe_param.sv
// mac_pe_param: weight-stationary systolic MAC processing element.
// Double-buffered weight (shadow/active), two-stage multiply then accumulate,
// registered east/south forwarding for tiling into an R x C array.
// Optional build macro MAC_PE_SAT_EN: saturating stage-2 add plus sticky sat_flag.
module mac_pe_param #(
    parameter int unsigned ACT_W  = 8,
    parameter int unsigned WGT_W  = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACT_W-1:0] act_in,
    input  logic             act_valid_in,
    output logic [ACT_W-1:0] act_out,
    output logic             act_valid_out,
    input  logic [WGT_W-1:0] wgt_in,
    input  logic             wgt_load,
    input  logic             wgt_swap,
    output logic [WGT_W-1:0] wgt_out,
    input  logic [ACC_W-1:0] psum_in,
    output logic [ACC_W-1:0] psum_out,
    output logic             psum_valid_out
`ifdef MAC_PE_SAT_EN
    ,
    output logic             sat_flag
`endif
);

    localparam int unsigned PW = ACT_W + WGT_W;

    if (ACC_W < PW) begin : g_acc_w_check
        $error("mac_pe_param: ACC_W must be >= ACT_W + WGT_W");
    end

    logic [ACT_W-1:0] act_q,    act_d;
    logic             act_v_q,  act_v_d;
    logic [WGT_W-1:0] shadow_q, shadow_d;
    logic [WGT_W-1:0] active_q, active_d;
    logic [PW-1:0]    mult_q,   mult_d;
    logic             v1_q,     v1_d;
    logic [ACC_W-1:0] psum_q,   psum_d;
    logic             psum_v_q, psum_v_d;

    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] mult_ext;
    logic [ACC_W-1:0] sum_res;
    logic             ovf;

    // Stage-1 product; operands are widened to PW first so the low PW bits are
    // the correct two's-complement product in signed mode.
    always_comb begin
        logic          act_sx;
        logic          wgt_sx;
        logic [PW-1:0] act_ext;
        logic [PW-1:0] wgt_ext;
        act_sx  = (SIGNED != 0) && act_in[ACT_W-1];
        wgt_sx  = (SIGNED != 0) && active_q[WGT_W-1];
        act_ext = {{WGT_W{act_sx}}, act_in};
        wgt_ext = {{ACT_W{wgt_sx}}, active_q};
        prod    = act_ext * wgt_ext;
    end

    // Extend the registered product to accumulator width (zero or sign).
    if (ACC_W > PW) begin : g_ext
        always_comb begin
            logic mult_sx;
            mult_sx  = (SIGNED != 0) && mult_q[PW-1];
            mult_ext = {{(ACC_W-PW){mult_sx}}, mult_q};
        end
    end else begin : g_noext
        always_comb mult_ext = mult_q[ACC_W-1:0];
    end

`ifdef MAC_PE_SAT_EN
    logic sat_q, sat_d;

    // Stage-2 saturating add: unsigned clamps on carry-out, signed clamps
    // towards the sign of the operands when both share a sign the result lacks.
    always_comb begin
        logic [ACC_W:0]   sum_wide;
        logic [ACC_W-1:0] sum_wrap;
        logic [ACC_W-1:0] sat_val;
        sum_wide = {1'b0, psum_in} + {1'b0, mult_ext};
        sum_wrap = sum_wide[ACC_W-1:0];
        if (SIGNED != 0) begin
            ovf     = (psum_in[ACC_W-1] == mult_ext[ACC_W-1]) &&
                      (sum_wrap[ACC_W-1] != psum_in[ACC_W-1]);
            sat_val = psum_in[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf     = sum_wide[ACC_W];
            sat_val = '1;
        end
        sum_res = ovf ? sat_val : sum_wrap;
    end
`else
    // Stage-2 add wraps modulo 2^ACC_W.
    always_comb begin
        ovf     = 1'b0;
        sum_res = psum_in + mult_ext;
    end
`endif

    // Next-state for forwarding, weight buffers and both pipeline stages.
    always_comb begin
        act_d    = act_in;
        act_v_d  = act_valid_in;
        shadow_d = wgt_load ? wgt_in : shadow_q;
        active_d = wgt_swap ? shadow_q : active_q;
        v1_d     = act_valid_in;
        mult_d   = act_valid_in ? prod : mult_q;
        psum_v_d = v1_q;
        psum_d   = v1_q ? sum_res : psum_q;
    end

    // Register bank; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q    <= '0;
            act_v_q  <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            mult_q   <= '0;
            v1_q     <= 1'b0;
            psum_q   <= '0;
            psum_v_q <= 1'b0;
        end else begin
            act_q    <= act_d;
            act_v_q  <= act_v_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            mult_q   <= mult_d;
            v1_q     <= v1_d;
            psum_q   <= psum_d;
            psum_v_q <= psum_v_d;
        end
    end

`ifdef MAC_PE_SAT_EN
    // Sticky saturation flag, cleared only by reset.
    always_comb sat_d = sat_q | (v1_q & ovf);

    // Saturation flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign sat_flag = sat_q;
`endif

    assign act_out        = act_q;
    assign act_valid_out  = act_v_q;
    assign wgt_out        = shadow_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_v_q;

endmodule

// File: tb/tb_mac_pe_param.sv
// Bench for mac_pe_param: an unsigned and a signed instance share stimulus;
// a reference model pushes expected sums into a scoreboard, a negedge
// monitor pops and compares them.
module tb_mac_pe_param;

    localparam int unsigned ACT_W = 8;
    localparam int unsigned WGT_W = 8;
    localparam int unsigned ACC_W = 24;
    localparam longint MASK = (longint'(1) << ACC_W) - 1;
    localparam longint SMAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (ACC_W - 1));

    logic             clk;
    logic             rst_n;
    logic [ACT_W-1:0] act_in;
    logic             act_valid_in;
    logic [WGT_W-1:0] wgt_in;
    logic             wgt_load;
    logic             wgt_swap;
    logic [ACC_W-1:0] psum_in;

    logic [ACT_W-1:0] act_out_u, act_out_s;
    logic             av_u, av_s;
    logic [WGT_W-1:0] wgt_out_u, wgt_out_s;
    logic [ACC_W-1:0] psum_u, psum_s;
    logic             pv_u, pv_s;
`ifdef MAC_PE_SAT_EN
    logic             sf_u, sf_s;
`endif

    mac_pe_param #(.ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(act_out_u), .act_valid_out(av_u),
        .wgt_in(wgt_in), .wgt_load(wgt_load), .wgt_swap(wgt_swap), .wgt_out(wgt_out_u),
        .psum_in(psum_in), .psum_out(psum_u), .psum_valid_out(pv_u)
`ifdef MAC_PE_SAT_EN
        , .sat_flag(sf_u)
`endif
    );

    mac_pe_param #(.ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(act_out_s), .act_valid_out(av_s),
        .wgt_in(wgt_in), .wgt_load(wgt_load), .wgt_swap(wgt_swap), .wgt_out(wgt_out_s),
        .psum_in(psum_in), .psum_out(psum_s), .psum_valid_out(pv_s)
`ifdef MAC_PE_SAT_EN
        , .sat_flag(sf_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        longint      val_u;
        longint      val_s;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    longint      hold_u = 0;
    longint      hold_s = 0;

    // Reference model state: plain integer view of the weights and the
    // product waiting for its partial sum.
    longint m_shadow = 0, m_active = 0, m_pu = 0, m_ps = 0;
    bit     m_v1 = 1'b0, m_fu = 1'b0, m_fs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sxw(input longint v, input int w);
        return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic step(input logic [7:0] a, input bit av, input logic [7:0] w,
                        input bit ld, input bit sw, input logic [23:0] p, input bit rst);
        longint su, ss, ns;
        act_in = a; act_valid_in = av; wgt_in = w;
        wgt_load = ld; wgt_swap = sw; psum_in = p; rst_n = ~rst;
        if (rst) begin
            m_shadow = 0; m_active = 0; m_v1 = 1'b0; m_fu = 1'b0; m_fs = 1'b0;
        end else begin
            if (m_v1) begin
                su = longint'(p) + m_pu;
                ss = sxw(longint'(p), ACC_W) + m_ps;
`ifdef MAC_PE_SAT_EN
                if (su > MASK) begin su = MASK; m_fu = 1'b1; end
                if (ss > SMAX) begin ss = SMAX; m_fs = 1'b1; end
                else if (ss < SMIN) begin ss = SMIN; m_fs = 1'b1; end
`endif
                sb.push_back('{cyc + 1, su & MASK, ss & MASK});
            end
            if (av) begin
                m_pu = longint'(a) * m_active;
                m_ps = sxw(longint'(a), ACT_W) * sxw(m_active, WGT_W);
            end
            m_v1 = av;
            ns = ld ? longint'(w) : m_shadow;
            m_active = sw ? m_shadow : m_active;
            m_shadow = ns;
        end
        @(posedge clk);
        if (rst) begin hold_u = 0; hold_s = 0; end
        #1;
        chk("act_out_u", act_out_u, rst ? 64'd0 : 64'(a));
        chk("act_out_s", act_out_s, rst ? 64'd0 : 64'(a));
        chk("act_valid_out_u", av_u, rst ? 64'd0 : 64'(av));
        chk("act_valid_out_s", av_s, rst ? 64'd0 : 64'(av));
        chk("wgt_out_u", wgt_out_u, m_shadow);
        chk("wgt_out_s", wgt_out_s, m_shadow);
`ifdef MAC_PE_SAT_EN
        chk("sat_flag_u", sf_u, m_fu);
        chk("sat_flag_s", sf_s, m_fs);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever a result is due and checks that
    // psum_out holds between results.
    exp_t e;
    bit   exp_v;
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL sb_missed: result due at cycle %0d not presented, expected 0x%0h",
                         sb[0].cyc, sb[0].val_u);
                void'(sb.pop_front());
            end
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("psum_valid_u", pv_u, exp_v);
            chk("psum_valid_s", pv_s, exp_v);
            if (exp_v) begin
                e = sb.pop_front();
                chk("psum_u", psum_u, e.val_u);
                chk("psum_s", psum_s, e.val_s);
                hold_u = e.val_u;
                hold_s = e.val_s;
            end else begin
                chk("psum_hold_u", psum_u, hold_u);
                chk("psum_hold_s", psum_s, hold_s);
            end
        end
    end

    initial begin
        rst_n = 1'b0; act_in = '0; act_valid_in = 1'b0; wgt_in = '0;
        wgt_load = 1'b0; wgt_swap = 1'b0; psum_in = '0;
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b1);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b1);
        mon_en = 1'b1;

        // Basic: weight 3, act 5, psum 100 -> 115
        step(8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        step(8'd5, 1'b1, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd100, 1'b0);
        idle(2);

        // Streaming with weight 2, then a single-cycle bubble
        step(8'd0, 1'b0, 8'd2, 1'b1, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        step(8'd1, 1'b1, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        step(8'd2, 1'b1, 8'd0, 1'b0, 1'b0, 24'd10, 1'b0);
        step(8'd3, 1'b1, 8'd0, 1'b0, 1'b0, 24'd20, 1'b0);
        step(8'd4, 1'b1, 8'd0, 1'b0, 1'b0, 24'd30, 1'b0);
        step(8'd5, 1'b1, 8'd0, 1'b0, 1'b0, 24'd40, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd50, 1'b0);
        step(8'd6, 1'b1, 8'd0, 1'b0, 1'b0, 24'd7, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd60, 1'b0);
        idle(2);

        // Overflow: 255 * 255 + 0xFFFFFF
        step(8'd0, 1'b0, 8'd255, 1'b1, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        step(8'd255, 1'b1, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0);
        idle(2);

        // Signed operands: 3 * -2 + 10, then -128 * -128 + 0
        step(8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'h80, 1'b1, 1'b1, 24'd0, 1'b0);
        step(8'hFE, 1'b1, 8'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        step(8'h80, 1'b1, 8'd0, 1'b0, 1'b0, 24'd10, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        idle(2);

        // Load/swap collision: shadow 7, active 1
        step(8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd7, 1'b1, 1'b1, 24'd0, 1'b0);
        step(8'd10, 1'b1, 8'd9, 1'b1, 1'b1, 24'd0, 1'b0);
        step(8'd10, 1'b1, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        idle(2);

        // Reset while two products are in flight
        step(8'd1, 1'b1, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        step(8'd2, 1'b1, 8'd0, 1'b0, 1'b0, 24'd5, 1'b0);
        step(8'd3, 1'b1, 8'd0, 1'b0, 1'b0, 24'd6, 1'b1);
        idle(3);
        step(8'd0, 1'b0, 8'd4, 1'b1, 1'b1, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        step(8'd4, 1'b1, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        step(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 24'd33, 1'b0);
        idle(2);

        // Randomised traffic including near-full partial sums and rare resets
        for (int i = 0; i < 400; i++) begin
            logic [23:0] p;
            p = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(24'hFF0000, 24'hFFFFFF))
                                           : 24'($urandom);
            if ($urandom_range(0, 7) == 0) p = 24'h7FFF00 + 24'($urandom_range(0, 255));
            step(8'($urandom), $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, p,
                 $urandom_range(0, 59) == 0);
        end
        idle(4);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
